// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and reset/vector defaults for the fetch-stage PC sequencer.
// Branch and jump opcode enums match the decoder's br_op/j_op fields.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLEZ = 3'd5,
        BR_BLTZ = 3'd6
    } br_op_e;

    typedef enum logic [2:0] {
        J_NONE = 3'd0,
        J_J    = 3'd1,
        J_JAL  = 3'd2,
        J_JR   = 3'd3,
        J_JALR = 3'd4
    } j_op_e;

    function automatic logic br_cond(input br_op_e op, input logic zero,
                                     input logic great, input logic less);
        logic hit;
        hit = 1'b0;
        case (op)
            BR_BEQ:  hit = zero;
            BR_BNE:  hit = !zero;
            BR_BGEZ: hit = zero | great;
            BR_BGTZ: hit = great;
            BR_BLEZ: hit = zero | less;
            BR_BLTZ: hit = less;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// D-stage/F-stage bundle of the PC sequencer: decode inputs, exception
// controls, stall, and the fetch PC / RAS status outputs.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic            stall;
    logic            d_valid;
    logic [XLEN-1:0] d_pc4;
    br_op_e          br_op;
    j_op_e           j_op;
    logic            d_rs_is_ra;
    logic            zero;
    logic            great;
    logic            less;
    logic [15:0]     imm16;
    logic [25:0]     instr_index;
    logic [XLEN-1:0] jr_target;
    logic            exc_req;
    logic            eret;
    logic [XLEN-1:0] epc;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] npc;
    logic            taken;
    logic [XLEN-1:0] ras_top;
    logic            ras_valid;
    logic            ras_miss;
    logic            pc_misalign;

    modport master (
        output stall, d_valid, d_pc4, br_op, j_op, d_rs_is_ra,
               zero, great, less, imm16, instr_index, jr_target,
               exc_req, eret, epc,
        input  pc, pc4, npc, taken, ras_top, ras_valid, ras_miss, pc_misalign
    );

    modport slave (
        input  stall, d_valid, d_pc4, br_op, j_op, d_rs_is_ra,
               zero, great, less, imm16, instr_index, jr_target,
               exc_req, eret, epc,
        output pc, pc4, npc, taken, ras_top, ras_valid, ras_miss, pc_misalign
    );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is a no-op, push+pop together replaces the top entry.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (cnt == CW'(DEPTH)) ? cnt : cnt + CW'(1);
    endfunction

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_p1;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   cnt_p1;
    logic            empty;
    logic            replace;

    assign top_idx = ptr_p1 - PW'(1);
    assign empty   = (cnt_p1 == '0);
    assign replace = push && pop && !empty;
    assign valid   = !empty;
    assign top     = empty ? '0 : mem[top_idx];

    // ---- pointer / occupancy (stage p1)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_p1 <= '0;
            cnt_p1 <= '0;
        end else if (replace) begin
            ptr_p1 <= ptr_p1;
        end else if (push) begin
            ptr_p1 <= ptr_p1 + PW'(1);
            cnt_p1 <= sat_inc(cnt_p1);
        end else if (pop && !empty) begin
            ptr_p1 <= top_idx;
            cnt_p1 <= cnt_p1 - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[replace ? top_idx : ptr_p1] <= data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register and next-PC selection with RAS-based JR $31 check.
// Optional PC_SEQ_PERF_EN adds taken_cnt / ras_miss_cnt performance counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_sequencer_if.slave      bus
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]        taken_cnt,
    output logic [31:0]        ras_miss_cnt
`endif
);

    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] base,
                                                      input logic [15:0]     off16);
        logic signed [XLEN-1:0] off;
        off = XLEN'($signed(off16));
        off = off <<< 2;
        return base + $unsigned(off);
    endfunction

    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] npc_p0;
    logic [XLEN-1:0] xfer_target_p0;
    logic            br_sel_p0;
    logic            j_sel_p0;
    logic            xfer_p0;
    logic            advance_p0;
    logic            ras_push_p0;
    logic            ras_pop_p0;
    logic            ras_miss_p0;
    logic            ras_miss_p1;
    logic [XLEN-1:0] ras_top_p1;
    logic            ras_valid_p1;

    // ---- stage p0: D-stage decode of redirect and next-PC select
    always_comb begin
        br_sel_p0      = (bus.br_op != BR_NONE);
        j_sel_p0       = !br_sel_p0 && (bus.j_op != J_NONE);
        xfer_target_p0 = bus.jr_target;
        if (br_sel_p0) begin
            xfer_target_p0 = branch_target(bus.d_pc4, bus.imm16);
        end else if (bus.j_op == J_J || bus.j_op == J_JAL) begin
            xfer_target_p0 = {bus.d_pc4[XLEN-1:28], bus.instr_index, 2'b00};
        end
        xfer_p0 = bus.d_valid &&
                  ((br_sel_p0 && br_cond(bus.br_op, bus.zero, bus.great, bus.less)) ||
                   j_sel_p0);

        if (bus.exc_req) begin
            npc_p0 = EXC_VEC;
        end else if (bus.eret) begin
            npc_p0 = bus.epc;
        end else if (xfer_p0) begin
            npc_p0 = xfer_target_p0;
        end else begin
            npc_p0 = pc_p1 + XLEN'(4);
        end
    end

    // An exception must be taken even while the pipeline is held.
    assign advance_p0 = !bus.stall || bus.exc_req;

    always_comb begin
        ras_push_p0 = 1'b0;
        ras_pop_p0  = 1'b0;
        if (bus.d_valid && !bus.stall && !bus.exc_req && j_sel_p0) begin
            ras_push_p0 = (bus.j_op == J_JAL) || (bus.j_op == J_JALR);
            ras_pop_p0  = bus.d_rs_is_ra &&
                          ((bus.j_op == J_JR) || (bus.j_op == J_JALR));
        end
        ras_miss_p0 = ras_pop_p0 && ras_valid_p1 && (ras_top_p1 != bus.jr_target);
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (ras_push_p0),
        .pop     (ras_pop_p0),
        .data    (bus.d_pc4 + XLEN'(4)),
        .top     (ras_top_p1),
        .valid   (ras_valid_p1)
    );

    // ---- stage p1: PC register and mispredict pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_p1       <= RESET_PC;
            ras_miss_p1 <= 1'b0;
        end else begin
            if (advance_p0) begin
                pc_p1 <= npc_p0;
            end
            ras_miss_p1 <= ras_miss_p0;
        end
    end

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            taken_cnt    <= '0;
            ras_miss_cnt <= '0;
        end else if (!bus.stall) begin
            if (xfer_p0 && !bus.exc_req && !bus.eret) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
            if (ras_miss_p0) begin
                ras_miss_cnt <= ras_miss_cnt + 32'd1;
            end
        end
    end
`endif

    assign bus.pc          = pc_p1;
    assign bus.pc4         = pc_p1 + XLEN'(4);
    assign bus.npc         = npc_p0;
    assign bus.taken       = xfer_p0;
    assign bus.ras_top     = ras_top_p1;
    assign bus.ras_valid   = ras_valid_p1;
    assign bus.ras_miss    = ras_miss_p1;
    assign bus.pc_misalign = |pc_p1[1:0];

endmodule
